// File: rtl/usb_ep0_in_sequencer.sv
// EP0 IN data-stage sequencer: walks a descriptor ROM window in max-packet chunks,
// loads each chunk into the TX FIFO and handshakes it with the packet engine.
// state    | meaning
// IDLE     | waiting for start
// LOAD     | size next packet (min of remaining, MAXPKT)
// FETCH    | ROM read / FIFO push, two cycles per byte
// READY    | packet in FIFO, waiting for IN token
// WAIT_ACK | packet sent, waiting for ACK or timeout
module usb_ep0_in_sequencer #(
    parameter int MAXPKT = 64,
    parameter int ROM_AW = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROM_AW-1:0] rom_base,
    input  logic [7:0]        rom_len,
    input  logic              req_zlp,
    input  logic              abort,
    input  logic              in_token,
    input  logic              ack_rcvd,
    input  logic              tx_timeout,
    input  logic              tx_full,
    input  logic [7:0]        rom_data,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              tx_push,
    output logic [7:0]        tx_data,
    output logic              tx_flush,
    output logic              pkt_ready,
    output logic [6:0]        pkt_len,
    output logic              data_pid,
    output logic              send,
    output logic              nak,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_READY, S_WAIT_ACK} state_t;

    localparam logic [7:0] MAXPKT_B = 8'(MAXPKT);

    state_t            r_state, w_state_nxt;
    logic [ROM_AW-1:0] r_cur_addr, w_cur_addr_nxt;
    logic [ROM_AW-1:0] r_pkt_start, w_pkt_start_nxt;
    logic [7:0]        r_remaining, w_remaining_nxt;
    logic              r_zlp_pend, w_zlp_pend_nxt;
    logic [6:0]        r_pkt_len, w_pkt_len_nxt;
    logic [6:0]        r_byte_cnt, w_byte_cnt_nxt;
    logic              r_phase, w_phase_nxt;
    logic              r_data_pid, w_data_pid_nxt;
    logic              r_send, w_send_nxt;
    logic              r_nak, w_nak_nxt;
    logic              r_done, w_done_nxt;
    logic              r_flush, w_flush_nxt;
    logic [7:0]        w_chunk;
    logic [7:0]        w_remaining_after;
    logic              w_push;

    assign w_chunk = (r_remaining > MAXPKT_B) ? MAXPKT_B : r_remaining;
    // Cycle B also holds off while full; the ROM address is unchanged so rom_data stays valid.
    assign w_push  = (r_state == S_FETCH) && r_phase && !tx_full && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_pkt_start <= '0;
            r_remaining <= '0;
            r_zlp_pend  <= 1'b0;
            r_pkt_len   <= '0;
            r_byte_cnt  <= '0;
            r_phase     <= 1'b0;
            r_data_pid  <= 1'b0;
            r_send      <= 1'b0;
            r_nak       <= 1'b0;
            r_done      <= 1'b0;
            r_flush     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_addr  <= w_cur_addr_nxt;
            r_pkt_start <= w_pkt_start_nxt;
            r_remaining <= w_remaining_nxt;
            r_zlp_pend  <= w_zlp_pend_nxt;
            r_pkt_len   <= w_pkt_len_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_data_pid  <= w_data_pid_nxt;
            r_send      <= w_send_nxt;
            r_nak       <= w_nak_nxt;
            r_done      <= w_done_nxt;
            r_flush     <= w_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cur_addr_nxt    = r_cur_addr;
        w_pkt_start_nxt   = r_pkt_start;
        w_remaining_nxt   = r_remaining;
        w_zlp_pend_nxt    = r_zlp_pend;
        w_pkt_len_nxt     = r_pkt_len;
        w_byte_cnt_nxt    = r_byte_cnt;
        w_phase_nxt       = r_phase;
        w_data_pid_nxt    = r_data_pid;
        w_send_nxt        = 1'b0;
        w_nak_nxt         = 1'b0;
        w_done_nxt        = 1'b0;
        w_flush_nxt       = 1'b0;
        w_remaining_after = r_remaining - {1'b0, r_pkt_len};

        if (abort) begin
            w_flush_nxt = (r_state != S_IDLE);
            w_phase_nxt = 1'b0;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_cur_addr_nxt  = rom_base;
                        w_pkt_start_nxt = rom_base;
                        w_remaining_nxt = rom_len;
                        w_zlp_pend_nxt  = req_zlp && (rom_len != 8'd0) &&
                                          ((rom_len % MAXPKT_B) == 8'd0);
                        w_data_pid_nxt  = 1'b1;
                        w_state_nxt     = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_nak_nxt      = in_token;
                    w_pkt_len_nxt  = w_chunk[6:0];
                    w_byte_cnt_nxt = '0;
                    w_phase_nxt    = 1'b0;
                    w_state_nxt    = (w_chunk == 8'd0) ? S_READY : S_FETCH;
                end
                S_FETCH: begin
                    w_nak_nxt = in_token;
                    if (!r_phase) begin
                        if (!tx_full) w_phase_nxt = 1'b1;
                    end else if (w_push) begin
                        w_phase_nxt    = 1'b0;
                        w_cur_addr_nxt = r_cur_addr + 1'b1;
                        w_byte_cnt_nxt = r_byte_cnt + 7'd1;
                        if (r_byte_cnt + 7'd1 == r_pkt_len) w_state_nxt = S_READY;
                    end
                end
                S_READY: begin
                    if (in_token) begin
                        w_send_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (ack_rcvd) begin
                        w_remaining_nxt = w_remaining_after;
                        w_pkt_start_nxt = r_cur_addr;
                        w_data_pid_nxt  = ~r_data_pid;
                        if (w_remaining_after != 8'd0) begin
                            w_state_nxt = S_LOAD;
                        end else if ((r_pkt_len != 7'd0) && r_zlp_pend) begin
                            w_zlp_pend_nxt = 1'b0;
                            w_state_nxt    = S_LOAD;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else if (tx_timeout) begin
                        w_flush_nxt    = 1'b1;
                        w_cur_addr_nxt = r_pkt_start;
                        w_state_nxt    = S_LOAD;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign rom_addr  = r_cur_addr;
    assign tx_push   = w_push;
    assign tx_data   = w_push ? rom_data : 8'd0;
    assign tx_flush  = r_flush;
    assign pkt_ready = (r_state == S_READY) || (r_state == S_WAIT_ACK);
    assign pkt_len   = r_pkt_len;
    assign data_pid  = r_data_pid;
    assign send      = r_send;
    assign nak       = r_nak;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_usb_ep0_in_sequencer.sv
// Randomized bench for usb_ep0_in_sequencer: a packet-list model of each data stage
// predicts packet sizes, PIDs and the exact ROM byte stream.
module tb_usb_ep0_in_sequencer;
    localparam int MAXPKT = 64;
    localparam int ROM_AW = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, req_zlp = 1'b0, abort = 1'b0, in_token = 1'b0;
    logic ack_rcvd = 1'b0, tx_timeout = 1'b0, tx_full = 1'b0;
    logic [ROM_AW-1:0] rom_base = '0;
    logic [7:0] rom_len = '0;
    logic [7:0] rom_data;
    logic [ROM_AW-1:0] rom_addr;
    logic tx_push, tx_flush, pkt_ready, data_pid, send, nak, busy, done;
    logic [7:0] tx_data;
    logic [6:0] pkt_len;

    usb_ep0_in_sequencer #(.MAXPKT(MAXPKT), .ROM_AW(ROM_AW)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_base(rom_base), .rom_len(rom_len),
        .req_zlp(req_zlp), .abort(abort), .in_token(in_token), .ack_rcvd(ack_rcvd),
        .tx_timeout(tx_timeout), .tx_full(tx_full), .rom_data(rom_data),
        .rom_addr(rom_addr), .tx_push(tx_push), .tx_data(tx_data), .tx_flush(tx_flush),
        .pkt_ready(pkt_ready), .pkt_len(pkt_len), .data_pid(data_pid), .send(send),
        .nak(nak), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] rom_mem [0:(1<<ROM_AW)-1];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int vectors = 0;
    int miscompares = 0;

    // Stage model: ordered list of packets the host must eventually receive.
    int n_pkts;
    int exp_len [0:7];
    int exp_pid [0:7];
    int exp_off [0:7];
    int stage_base;
    int cur = 0;
    int seen_cur = 0;
    int attempt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic build_model(input int base, input int len, input int zlp);
        int rem, off, c;
        n_pkts = 0; rem = len; off = 0;
        stage_base = base;
        if (len == 0) begin
            exp_len[0] = 0; exp_off[0] = 0; n_pkts = 1;
        end else begin
            while (rem > 0) begin
                c = (rem > MAXPKT) ? MAXPKT : rem;
                exp_len[n_pkts] = c; exp_off[n_pkts] = off;
                n_pkts++; off += c; rem -= c;
            end
            if (zlp != 0 && (len % MAXPKT) == 0) begin
                exp_len[n_pkts] = 0; exp_off[n_pkts] = off; n_pkts++;
            end
        end
        for (int i = 0; i < n_pkts; i++) exp_pid[i] = (i % 2 == 0) ? 1 : 0;
        cur = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_tx_push"}, 32'(tx_push), 0);
        chk({tag, "_tx_data"}, 32'(tx_data), 0);
        chk({tag, "_tx_flush"}, 32'(tx_flush), 0);
        chk({tag, "_pkt_ready"}, 32'(pkt_ready), 0);
        chk({tag, "_pkt_len"}, 32'(pkt_len), 0);
        chk({tag, "_data_pid"}, 32'(data_pid), 0);
        chk({tag, "_send"}, 32'(send), 0);
        chk({tag, "_nak"}, 32'(nak), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Byte-stream checker: every push must be the next byte of the current packet attempt.
    always @(negedge clk) begin
        if (rst) begin
            if (!busy || cur != seen_cur) begin
                attempt  = 0;
                seen_cur = cur;
            end
            if (tx_flush) attempt = 0;
            if (tx_push) begin
                chk("push_busy", 32'(busy), 1);
                chk("push_not_full", 32'(tx_full), 0);
                if (cur < n_pkts) begin
                    chk("push_in_pkt", 32'(attempt < exp_len[cur]), 1);
                    chk("tx_data", 32'(tx_data),
                        32'(rom_mem[ROM_AW'(stage_base + exp_off[cur] + attempt)]));
                end else begin
                    chk("push_after_last", 0, 1);
                end
                attempt++;
            end
            if (pkt_ready) chk("ready_implies_busy", 32'(busy), 1);
        end
    end

    // One data stage. abort_pkt/rst_pkt = -1 disables that disturbance.
    task automatic run_stage(input int base, input int len, input int zlp, input int stall,
                             input int n_to, input int abort_pkt, input int abort_cyc,
                             input int rst_pkt);
        int budget, to_left, r;
        logic got, pr, was_tok, both, last;
        build_model(base, len, zlp);
        to_left = n_to;
        rom_base = ROM_AW'(base); rom_len = 8'(len); req_zlp = zlp[0];
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("pid_after_start", 32'(data_pid), 1);
        while (cur < n_pkts) begin
            got = 1'b0; budget = 0;
            while (!got) begin
                budget++;
                if (budget > 800) begin
                    chk("ready_timeout", 0, 1);
                    abort = 1'b1; tick; abort = 1'b0; tx_full = 1'b0;
                    return;
                end
                if (cur == abort_pkt && budget == abort_cyc) begin
                    tx_full = 1'b0; abort = 1'b1;
                    tick;
                    abort = 1'b0;
                    chk("abort_flush", 32'(tx_flush), 1);
                    chk("abort_busy", 32'(busy), 0);
                    chk("abort_ready", 32'(pkt_ready), 0);
                    tick;
                    chk("abort_flush_pulse", 32'(tx_flush), 0);
                    return;
                end
                tx_full  = (stall != 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
                in_token = ($urandom_range(0, 7) == 0);
                start    = ($urandom_range(0, 15) == 0);
                rom_len  = 8'($urandom_range(0, 255));
                pr = pkt_ready; was_tok = in_token;
                tick;
                in_token = 1'b0; start = 1'b0;
                if (was_tok) begin
                    if (pr) begin
                        chk("send_on_token", 32'(send), 1);
                        chk("no_nak_ready", 32'(nak), 0);
                        chk("pkt_len", 32'(pkt_len), 32'(exp_len[cur]));
                        chk("pkt_pid", 32'(data_pid), 32'(exp_pid[cur]));
                        chk("pkt_bytes", 32'(attempt), 32'(exp_len[cur]));
                        got = 1'b1;
                    end else begin
                        chk("nak_on_token", 32'(nak), 1);
                        chk("no_send_fetch", 32'(send), 0);
                    end
                end else begin
                    chk("no_spurious_send", 32'(send), 0);
                    chk("no_spurious_nak", 32'(nak), 0);
                end
            end
            tx_full = 1'b0;
            r = $urandom_range(0, 3);
            for (int i = 0; i < r; i++) begin
                in_token = $urandom_range(0, 1);
                tick;
                in_token = 1'b0;
                chk("send_once", 32'(send), 0);
                chk("nak_in_wait", 32'(nak), 0);
                chk("ready_in_wait", 32'(pkt_ready), 1);
            end
            if (cur == rst_pkt) begin
                #2 rst = 1'b0;
                #1 check_all_zero("async_rst");
                @(negedge clk) rst = 1'b1;
                tick;
                return;
            end
            if (to_left > 0 && $urandom_range(0, 1) == 0) begin
                to_left--;
                tx_timeout = 1'b1;
                tick;
                tx_timeout = 1'b0;
                chk("to_flush", 32'(tx_flush), 1);
                chk("to_ready", 32'(pkt_ready), 0);
                chk("to_busy", 32'(busy), 1);
                chk("to_pid", 32'(data_pid), 32'(exp_pid[cur]));
                chk("to_done", 32'(done), 0);
            end else begin
                both = ($urandom_range(0, 4) == 0);
                ack_rcvd = 1'b1; tx_timeout = both;
                tick;
                ack_rcvd = 1'b0; tx_timeout = 1'b0;
                last = (cur == n_pkts - 1);
                chk("ack_ready", 32'(pkt_ready), 0);
                chk("ack_no_flush", 32'(tx_flush), 0);
                chk("ack_pid", 32'(data_pid), 32'(1 - exp_pid[cur]));
                chk("ack_done", 32'(done), 32'(last));
                chk("ack_busy", 32'(busy), 32'(!last));
                cur++;
            end
        end
        tick;
        chk("done_pulse", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = 8'($urandom_range(0, 255));
        #12;
        check_all_zero("reset");
        @(negedge clk) rst = 1'b1;
        tick;
        check_all_zero("post_reset");

        build_model(0, 18, 0);
        chk("m1_n", 32'(n_pkts), 1);
        chk("m1_len", 32'(exp_len[0]), 18);
        run_stage(0, 18, 0, 0, 0, -1, 0, -1);

        build_model(24, 130, 0);
        chk("m2_n", 32'(n_pkts), 3);
        chk("m2_len0", 32'(exp_len[0]), 64);
        chk("m2_len2", 32'(exp_len[2]), 2);
        chk("m2_pid1", 32'(exp_pid[1]), 0);
        chk("m2_addr2", 32'(stage_base + exp_off[2]), 152);
        run_stage(24, 130, 0, 0, 0, -1, 0, -1);

        build_model(100, 64, 1);
        chk("m3_n", 32'(n_pkts), 2);
        chk("m3_zlp_len", 32'(exp_len[1]), 0);
        chk("m3_zlp_pid", 32'(exp_pid[1]), 0);
        run_stage(100, 64, 1, 0, 0, -1, 0, -1);
        build_model(100, 64, 0);
        chk("m3b_n", 32'(n_pkts), 1);
        run_stage(100, 64, 0, 0, 0, -1, 0, -1);

        run_stage(8, 40, 0, 0, 2, -1, 0, -1);
        run_stage(200, 50, 0, 1, 0, -1, 0, -1);

        // tx_full held 5 cycles mid-fetch: no pushes at all during the hold
        build_model(60, 20, 0);
        rom_base = 9'd60; rom_len = 8'd20; req_zlp = 1'b0; start = 1'b1;
        tick; start = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("hold_no_push", 32'(tx_push), 0);
        end
        tx_full = 1'b0;
        abort = 1'b1; tick; abort = 1'b0;
        chk("hold_abort_busy", 32'(busy), 0);
        run_stage(60, 20, 0, 0, 0, -1, 0, -1);

        run_stage(300, 100, 0, 0, 0, 0, 40, -1);
        run_stage(5, 30, 0, 0, 0, -1, 0, 0);
        check_all_zero("after_rst_idle_pre");
        run_stage(7, 0, 0, 0, 1, -1, 0, -1);
        run_stage(500, 30, 0, 1, 0, -1, 0, -1);

        start = 1'b1; abort = 1'b1; rom_len = 8'd10;
        tick;
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", 32'(busy), 0);
        chk("idle_abort_no_flush", 32'(tx_flush), 0);

        for (int s = 0; s < 30; s++) begin
            int ab;
            ab = ($urandom_range(0, 4) == 0) ? 0 : -1;
            run_stage($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 2), ab,
                      $urandom_range(5, 60), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
